// File: rtl/dmem_lsu_port.sv
// dmem_lsu_port: load/store initiator for the DMEM BRAM port.
// Takes one RV32 load/store at a time and drives at most one BRAM access for it.
// Stores produce byte enables and lane-replicated write data. Loads sign- or
// zero-extend the addressed byte, halfword or word from the BRAM read data.
// Misaligned, out-of-range and illegal-width requests get an error response
// and never reach the BRAM.
module dmem_lsu_port #(
  parameter int          MEM_DEPTH = 4096,
  parameter logic [31:0] ADDR_BASE = 32'h0
) (
  input  logic        clkb,
  input  logic        rstb,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        bram_en,
  output logic        bram_rst,
  output logic [3:0]  bram_we,
  output logic [31:0] bram_addr,
  output logic [31:0] bram_din,
  input  logic [31:0] bram_dout
);

  localparam logic [31:0] MEM_BYTES = 32'(MEM_DEPTH * 4);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  lane_q, lane_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        we_q, we_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] off;
  logic        inRange;
  logic        funct3Ok;
  logic        aligned;
  logic        legal;
  logic [3:0]  storeWe;
  logic [31:0] storeDin;
  logic [31:0] loadData;

  // Offset into the BRAM; a request below ADDR_BASE wraps to a huge value and
  // therefore lands out of range.
  assign off       = req_addr - ADDR_BASE;
  assign inRange   = (off < MEM_BYTES);
  assign bram_addr = {off[31:2], 2'b00};
  assign bram_rst  = 1'b0;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // Request legality: width code allowed for this direction and natural alignment.
  always_comb begin
    funct3Ok = 1'b0;
    aligned  = 1'b0;
    case (req_funct3)
      3'b000: begin funct3Ok = 1'b1;     aligned = 1'b1;          end
      3'b001: begin funct3Ok = 1'b1;     aligned = ~off[0];       end
      3'b010: begin funct3Ok = 1'b1;     aligned = (off[1:0] == 2'b00); end
      3'b100: begin funct3Ok = ~req_we;  aligned = 1'b1;          end
      3'b101: begin funct3Ok = ~req_we;  aligned = ~off[0];       end
      default: begin funct3Ok = 1'b0;    aligned = 1'b0;          end
    endcase
    legal = funct3Ok && aligned && inRange;
  end

  // Store byte enables and lane-replicated write data for the addressed lane.
  always_comb begin
    storeWe  = 4'b0000;
    storeDin = 32'h0;
    case (req_funct3[1:0])
      2'b00: begin
        storeWe  = 4'b0001 << off[1:0];
        storeDin = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        storeWe  = off[1] ? 4'b1100 : 4'b0011;
        storeDin = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        storeWe  = 4'b1111;
        storeDin = req_wdata;
      end
      default: begin
        storeWe  = 4'b0000;
        storeDin = 32'h0;
      end
    endcase
  end

  // Load extraction from the BRAM word using the lane and width captured at accept.
  always_comb begin
    logic [7:0]  byteSel;
    logic [15:0] halfSel;
    byteSel  = 8'(bram_dout >> {lane_q, 3'b000});
    halfSel  = lane_q[1] ? bram_dout[31:16] : bram_dout[15:0];
    loadData = 32'h0;
    case (funct3_q)
      3'b000:  loadData = {{24{byteSel[7]}}, byteSel};
      3'b100:  loadData = {24'h0, byteSel};
      3'b001:  loadData = {{16{halfSel[15]}}, halfSel};
      3'b101:  loadData = {16'h0, halfSel};
      3'b010:  loadData = bram_dout;
      default: loadData = 32'h0;
    endcase
  end

  // Next-state and output logic; while reset is held nothing is accepted or issued.
  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    funct3_d  = funct3_q;
    we_d      = we_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    bram_en   = 1'b0;
    bram_we   = 4'b0000;
    bram_din  = 32'h0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (legal) begin
            bram_en  = 1'b1;
            bram_we  = req_we ? storeWe : 4'b0000;
            bram_din = req_we ? storeDin : 32'h0;
            lane_d   = off[1:0];
            funct3_d = req_funct3;
            we_d     = req_we;
            state_d  = WAIT;
          end else begin
            rdata_d = 32'h0;
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        rdata_d = we_q ? 32'h0 : loadData;
        err_d   = 1'b0;
        state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (rstb) begin
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      bram_en   = 1'b0;
      bram_we   = 4'b0000;
      bram_din  = 32'h0;
    end
  end

  // State and response registers; reset drops any in-flight request.
  always_ff @(posedge clkb) begin
    if (rstb) begin
      state_q  <= IDLE;
      lane_q   <= 2'b00;
      funct3_q <= 3'b000;
      we_q     <= 1'b0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lane_q   <= lane_d;
      funct3_q <= funct3_d;
      we_q     <= we_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

endmodule
